// File: rtl/srrc_tx_flt.sv
// Transmit SRRC pulse shaper: maps Gray-coded 4-ASK symbols to s1.17 levels
// and interpolates by 4 through a 17-tap symmetric polyphase FIR.
// One shaped, saturated sample leaves the block on every clock.
module srrc_tx_flt #(
  parameter logic signed [17:0] A_LEVEL = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic signed [17:0] out,
  output logic               out_valid,
  output logic [1:0]         phase,
  output logic               underrun
);

  localparam logic signed [17:0] A3_LEVEL = 18'(3 * A_LEVEL);
  localparam logic signed [20:0] SAT_MAX  = 21'sd131071;
  localparam logic signed [20:0] SAT_MIN  = -21'sd131072;

  // Gray code: 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a
  function automatic logic signed [17:0] map_sym(input logic [1:0] s);
    case (s)
      2'b00:   return -A3_LEVEL;
      2'b01:   return -A_LEVEL;
      2'b11:   return A_LEVEL;
      default: return A3_LEVEL;
    endcase
  endfunction

  // Only h[0..8] is stored; the upper half mirrors it. Indices past 16 are 0.
  function automatic logic signed [17:0] coef_at(input logic [4:0] idx);
    logic [4:0] m;
    m = (idx > 5'd8) ? (5'd16 - idx) : idx;
    if (idx > 5'd16) return '0;
    case (m)
      5'd0:    return 18'sd3259;
      5'd1:    return -18'sd3378;
      5'd2:    return -18'sd10461;
      5'd3:    return -18'sd12207;
      5'd4:    return -18'sd3946;
      5'd5:    return 18'sd14611;
      5'd6:    return 18'sd38196;
      5'd7:    return 18'sd57937;
      5'd8:    return 18'sd65624;
      default: return '0;
    endcase
  endfunction

  // Full 36-bit product, then floor-divide by 2^17 by keeping bits [34:17].
  function automatic logic signed [17:0] scaled_term(input logic signed [17:0] c,
                                                      input logic signed [17:0] x);
    logic signed [35:0] prod;
    prod = 36'(c) * 36'(x);
    return $signed(prod[34:17]);
  endfunction

  logic [1:0]         ph_reg;
  logic signed [17:0] d_reg [0:4];
  logic signed [17:0] out_reg;
  logic               out_valid_reg;
  logic [1:0]         phase_reg;
  logic               underrun_reg;

  logic signed [17:0] term_w [0:4];
  logic signed [20:0] acc_next;
  logic signed [17:0] sat_next;
  logic signed [17:0] d0_next;

  // One polyphase tap per delay-line slot: slot gi uses h[4*gi + ph].
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_tap
      logic [4:0] idx_w;
      assign idx_w       = 5'(4 * gi) + {3'b000, ph_reg};
      assign term_w[gi]  = scaled_term(coef_at(idx_w), d_reg[gi]);
    end
  endgenerate

  // Accumulate the truncated taps and clamp into the s1.17 output range.
  always_comb begin
    acc_next = '0;
    for (int k = 0; k < 5; k++) begin
      acc_next = acc_next + 21'(term_w[k]);
    end
    if (acc_next > SAT_MAX) begin
      sat_next = 18'sd131071;
    end else if (acc_next < SAT_MIN) begin
      sat_next = -18'sd131072;
    end else begin
      sat_next = acc_next[17:0];
    end
  end

  // An empty slot feeds a zero symbol into the delay line.
  assign d0_next   = sym_valid ? map_sym(sym_in) : '0;
  assign sym_ready = (ph_reg == 2'd3);

  // Phase counter, symbol delay line, and registered filter outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_reg        <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      phase_reg     <= '0;
      underrun_reg  <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        d_reg[k] <= '0;
      end
    end else begin
      ph_reg        <= ph_reg + 2'd1;
      out_reg       <= sat_next;
      out_valid_reg <= 1'b1;
      phase_reg     <= ph_reg;
      if (ph_reg == 2'd3) begin
        for (int k = 4; k > 0; k--) begin
          d_reg[k] <= d_reg[k-1];
        end
        d_reg[0]     <= d0_next;
        underrun_reg <= !sym_valid;
      end else begin
        underrun_reg <= 1'b0;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign phase     = phase_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_srrc_tx_flt.sv
// Bench for srrc_tx_flt: directed and random symbol streams compared against
// a convolution model (each accepted symbol adds h[j]*S to sample E+1+j).
module tb_srrc_tx_flt;

  logic               clk;
  logic               reset;
  logic [1:0]         sym_in;
  logic               sym_valid;
  logic               sym_ready;
  logic signed [17:0] out;
  logic               out_valid;
  logic [1:0]         phase;
  logic               underrun;

  int checks = 0;
  int errors = 0;

  // Model state: n counts edges since reset release; sv[e] is the level
  // accepted at edge e (0 when nothing was accepted).
  int n = 0;
  int sv      [0:4095];
  int out_log [0:4095];

  int h [0:16] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624,
                   57937, 38196, 14611, -3946, -12207, -10461, -3378, 3259};
  int imp_tab [0:16] = '{2444, -2534, -7846, -9156, -2960, 10958, 28647, 43452, 49218,
                         43452, 28647, 10958, -2960, -9156, -7846, -2534, 2444};

  srrc_tx_flt dut (
    .clk       (clk),
    .reset     (reset),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .out       (out),
    .out_valid (out_valid),
    .phase     (phase),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int level_of(input logic [1:0] s);
    case (s)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  function automatic int exp_out(input int nn);
    longint acc;
    acc = 0;
    for (int j = 0; j < 17; j++) begin
      if (nn - 1 - j >= 1) acc += (longint'(h[j]) * longint'(sv[nn-1-j])) >>> 17;
    end
    if (acc > 131071) acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4096; i++) begin
      sv[i] = 0;
      out_log[i] = 0;
    end
  endtask

  // One clock: drive inputs, advance the model, check every output at negedge.
  task automatic step(input logic v, input logic [1:0] s, output logic took);
    logic acc_edge;
    logic exp_ur;
    sym_valid = v;
    sym_in    = s;
    acc_edge  = ((n % 4) == 3);
    @(posedge clk);
    n++;
    sv[n]  = (acc_edge && v) ? level_of(s) : 0;
    exp_ur = acc_edge && !v;
    took   = acc_edge && v;
    @(negedge clk);
    out_log[n] = int'(out);
    check("out", out, exp_out(n));
    check("out_valid", out_valid, 1);
    check("phase", phase, (n - 1) % 4);
    check("underrun", underrun, exp_ur);
    check("sym_ready", sym_ready, ((n % 4) == 3) ? 1 : 0);
    if (took) $display("sym accepted edge=%0d code=%b level=%0d", n, s, sv[n]);
  endtask

  task automatic send(input logic [1:0] s);
    logic took;
    took = 1'b0;
    for (int i = 0; i < 4 && !took; i++) step(1'b1, s, took);
  endtask

  task automatic idle(input int k);
    logic took;
    for (int i = 0; i < k; i++) step(1'b0, 2'($urandom), took);
  endtask

  task automatic impulse_check(input string tag);
    int e;
    send(2'b10);
    e = n;
    idle(20);
    for (int j = 0; j < 17; j++) check(tag, out_log[e+1+j], imp_tab[j]);
    check({tag, "_tail"}, out_log[e+18], 0);
  endtask

  initial begin
    int e;
    logic took;
    reset     = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 2'b00;
    model_reset();

    // Reset held: outputs stay cleared while clocks run.
    repeat (3) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_underrun", underrun, 0);
      check("rst_sym_ready", sym_ready, 0);
    end
    reset = 1'b1;

    // Idle stream: zeros out, underrun every 4th cycle.
    idle(8);

    // Single +3a impulse.
    impulse_check("impulse");

    // Steady +a on every slot.
    for (int i = 0; i < 8; i++) send(2'b11);
    e = n;
    idle(1);
    check("steady_ph0", out_log[e+1], 16060);

    // Handshake stall: valid raised at ph=1, held until the ph=3 edge.
    while ((n % 4) != 1) step(1'b0, 2'b00, took);
    send(2'b01);
    idle(3);

    // Underrun in the middle of a stream.
    send(2'b10);
    send(2'b00);
    idle(4);
    send(2'b11);
    send(2'b01);
    idle(20);

    // Random stream with occasional empty slots.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) != 0) send(2'($urandom));
      else idle(4);
    end
    idle(20);

    // Mid-stream reset at ph=2 with a loaded delay line.
    send(2'b10);
    send(2'b01);
    while ((n % 4) != 2) step(1'b0, 2'b00, took);
    #1 reset = 1'b0;
    #1;
    check("mrst_out", out, 0);
    check("mrst_underrun", underrun, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_sym_ready", sym_ready, 0);
    repeat (2) begin
      @(negedge clk);
      check("mrst_hold_out", out, 0);
      check("mrst_hold_phase", phase, 0);
    end
    reset = 1'b1;
    model_reset();
    idle(2);
    impulse_check("impulse_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
